mux_rr_arbiter: RTL
===================

Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares a 4-input Mux datapath among four requesters.
- Drives the Mux Select input from a registered grant, so exactly one requester's data reaches DOut at a time.
- Enforces a maximum hold time per grant so no requester can starve the others.
- Sits directly in front of the Mux instance. Requester i owns Mux input DIn<i>.

Parameters:
- SelectSize, 2, width of Select; must be 2 (four requesters, fixed).
- MaxHold, 16, maximum consecutive cycles one owner may hold a grant; legal range 2..256.
- CountWidth, 8, width of the hold counter; must satisfy 2^CountWidth >= MaxHold.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset_N  input  1  asynchronous, active-low reset.
- Req  input  4  request lines; Req[i] high means requester i wants the Mux.
- Done  input  4  end-of-transfer strobes; only Done[owner] is honoured, other bits are ignored.
- Grant  output  4  one-hot grant, registered; all zeros when no owner.
- Select  output  SelectSize  encoded owner index, wired to Mux Select.
- Valid  output  1  high while a grant is active (Grant != 0).
- Expired  output  1  one-cycle pulse when a grant is revoked by MaxHold timeout.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-grant):
  - Grant=0, Select=0, Valid=0, Expired=0.
  - Pointer=0, HoldCount=0, State=IDLE.
- State register: IDLE, OWN.
- Winner function: first asserted bit of the candidate mask, scanning Pointer, Pointer+1, ... modulo 4.
- IDLE:
  - If Req != 0, compute the winner on the current Req.
  - Next edge: State=OWN, Grant=onehot(winner), Select=winner, Valid=1, HoldCount=0.
  - Latency: 1 cycle from Req to Grant.
  - If Req == 0, stay in IDLE. Select holds its last value and Grant=0.
- OWN: each cycle, evaluate the release conditions for owner o:
  - (a) Req[o]==0,
  - (b) Done[o]==1,
  - (c) HoldCount==MaxHold-1.
- No release condition true: HoldCount increments; Grant and Select are unchanged.
- Release (any condition true):
  - Pointer <= (o+1) mod 4.
  - Candidate mask = Req with bit o cleared.
  - Candidate nonzero: the winner of the mask (searched from o+1) is granted on the next edge, back-to-back with no idle cycle; HoldCount=0; State stays OWN.
  - Candidate zero: next edge Grant=0, Valid=0, State=IDLE.
  - A still-requesting former owner is re-granted from IDLE no earlier than the cycle after that.
- Expired:
  - Pulses high for the one cycle after a release caused only by (c), i.e. (a) and (b) false.
  - Not asserted when (a) or (b) coincides with (c).
- Simultaneous events: Done[o] together with new requests from others behaves as a normal release; the grant hands over in the next cycle.
- Done bits for non-owners, and Done while IDLE, are ignored.
- Select changes only on the cycle Grant changes. Grant is always one-hot or zero, never multi-hot.
- Pointer wraps 3 -> 0.
- HoldCount never exceeds MaxHold-1.

Test Plan:
- Reset check: assert Reset_N=0 mid-grant with Req=4'b1111 -> same cycle Grant=0, Select=0, Valid=0, Expired=0. After release with Req=4'b0100: Grant=4'b0100 and Select=2 one cycle later.
- Round-robin rotation: Req=4'b1111 held, each owner pulses Done after 3 cycles -> Select sequence 0,1,2,3,0 with no idle cycle between grants.
- Timeout: MaxHold=16, Req=4'b0011 held, no Done:
  - requester 0 is granted for exactly 16 cycles;
  - Expired pulses once;
  - Grant moves to 4'b0010.
- Single requester: Req=4'b1000 only, Done[3] pulsed -> Grant=0 for one cycle, then re-granted to 3 (Select=3).
- Request drop: owner 1 deasserts Req[1] while Req[2] is high -> next cycle Grant=4'b0100 and Expired=0. Done[0] pulsed during that grant -> ignored.
- Coincident release: Done[o] asserted on the cycle HoldCount==MaxHold-1 -> handover occurs and Expired stays 0.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 4-input mux; registered one-hot grant, 1-cycle req->grant latency.
// Owners release on request drop, done strobe or hold timeout; handover is back-to-back when another requester waits.
module mux_rr_arbiter #(
    parameter int SelectSize = 2,
    parameter int MaxHold    = 16,
    parameter int CountWidth = 8
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic [3:0]            i_req,
    input  logic [3:0]            i_done,
    output logic [3:0]            o_grant,
    output logic [SelectSize-1:0] o_select,
    output logic                  o_valid,
    output logic                  o_expired
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    localparam logic [CountWidth-1:0] HOLD_LAST = CountWidth'(MaxHold - 1);

    state_t                r_state;
    logic [3:0]            r_grant;
    logic [1:0]            r_sel;
    logic [1:0]            r_ptr;
    logic [CountWidth-1:0] r_hold;
    logic                  r_expired;

    state_t                w_state_nxt;
    logic [3:0]            w_grant_nxt;
    logic [1:0]            w_sel_nxt;
    logic [1:0]            w_ptr_nxt;
    logic [CountWidth-1:0] w_hold_nxt;
    logic                  w_expired_nxt;

    logic                  w_rel_a;
    logic                  w_rel_b;
    logic                  w_rel_c;
    logic                  w_release;
    logic [3:0]            w_cand;
    logic [1:0]            w_after_owner;
    logic [1:0]            w_win_idle;
    logic [1:0]            w_win_own;

    // First set bit of mask scanning start, start+1, ... modulo 4.
    function automatic logic [1:0] f_winner(input logic [3:0] mask, input logic [1:0] start);
        logic [1:0] idx;
        f_winner = start;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (mask[idx]) begin
                f_winner = idx;
            end
        end
    endfunction

    // The current owner is always r_sel while in OWN.
    assign w_rel_a       = !i_req[r_sel];
    assign w_rel_b       = i_done[r_sel];
    assign w_rel_c       = (r_hold == HOLD_LAST);
    assign w_release     = w_rel_a || w_rel_b || w_rel_c;
    assign w_cand        = i_req & ~(4'b0001 << r_sel);
    assign w_after_owner = r_sel + 2'd1;
    assign w_win_idle    = f_winner(i_req, r_ptr);
    assign w_win_own     = f_winner(w_cand, w_after_owner);

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_sel_nxt     = r_sel;
        w_ptr_nxt     = r_ptr;
        w_hold_nxt    = r_hold;
        w_expired_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (|i_req) begin
                    w_state_nxt = OWN;
                    w_grant_nxt = 4'b0001 << w_win_idle;
                    w_sel_nxt   = w_win_idle;
                    w_hold_nxt  = '0;
                end
            end
            OWN: begin
                if (w_release) begin
                    w_ptr_nxt     = w_after_owner;
                    w_expired_nxt = w_rel_c && !w_rel_a && !w_rel_b;
                    w_hold_nxt    = '0;
                    if (|w_cand) begin
                        w_grant_nxt = 4'b0001 << w_win_own;
                        w_sel_nxt   = w_win_own;
                    end else begin
                        w_grant_nxt = 4'b0000;
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_hold_nxt = r_hold + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= IDLE;
            r_grant   <= 4'b0000;
            r_sel     <= 2'd0;
            r_ptr     <= 2'd0;
            r_hold    <= '0;
            r_expired <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_sel     <= w_sel_nxt;
            r_ptr     <= w_ptr_nxt;
            r_hold    <= w_hold_nxt;
            r_expired <= w_expired_nxt;
        end
    end

    assign o_grant   = r_grant;
    assign o_select  = SelectSize'(r_sel);
    assign o_valid   = |r_grant;
    assign o_expired = r_expired;

endmodule
